// File: rtl/axi_burst_addr_gen_if.sv
// Command/beat bundle between the AXI_AHB bridge sequencer and the burst address generator.
// The bound_err signal exists only when BURST_4K_CHECK_EN is defined.
interface axi_burst_addr_gen_if #(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              adv;
    logic              busy;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  beat_cnt;
    logic              last;
    logic              done;
`ifdef BURST_4K_CHECK_EN
    logic              bound_err;
`endif

    modport master (
        output start, base_addr, len, size, burst, adv,
        input  busy, addr, beat_cnt, last, done
`ifdef BURST_4K_CHECK_EN
        , input bound_err
`endif
    );

    modport slave (
        input  start, base_addr, len, size, burst, adv,
        output busy, addr, beat_cnt, last, done
`ifdef BURST_4K_CHECK_EN
        , output bound_err
`endif
    );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Per-beat AXI address generator (FIXED/INCR/WRAP) for the AXI_AHB bridge.
// Define BURST_4K_CHECK_EN to add the registered bound_err 4 KB crossing flag.
module axi_burst_addr_gen #(
    parameter int ADDR_W   = 32,
    parameter int LEN_W    = 8,
    parameter int SIZE_MAX = 7
) (
    input  logic                 clk,
    input  logic                 resetn,
    axi_burst_addr_gen_if.slave  bus
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [LEN_W-1:0]  beat_cnt_reg, beat_cnt_next;
    logic [LEN_W-1:0]  len_reg, len_next;
    logic [2:0]        size_reg, size_next;
    logic [1:0]        burst_reg, burst_next;
    logic              done_reg, done_next;

    logic [2:0]        size_clamped;
    logic              busy, last;
    logic [ADDR_W-1:0] bytes, aligned_incr;
    logic              wrap_legal;
    logic [2:0]        wrap_log;
    logic [3:0]        wrap_shift;
    logic [ADDR_W-1:0] wrap_bytes, wrap_lower, wrap_next;

    assign size_clamped = (bus.size > 3'(SIZE_MAX)) ? 3'(SIZE_MAX) : bus.size;
    assign busy         = (state_reg == BURST);
    assign last         = busy && (beat_cnt_reg == len_reg);

    // Later beats are always size-aligned, which lets an unaligned first beat fall in naturally.
    assign bytes        = ADDR_W'(1) << size_reg;
    assign aligned_incr = (addr_reg & ~(bytes - ADDR_W'(1))) + bytes;

    always_comb begin
        wrap_legal = 1'b1;
        wrap_log   = 3'd0;
        case (len_reg)
            LEN_W'(1):  wrap_log = 3'd1;
            LEN_W'(3):  wrap_log = 3'd2;
            LEN_W'(7):  wrap_log = 3'd3;
            LEN_W'(15): wrap_log = 3'd4;
            default:    wrap_legal = 1'b0;
        endcase
    end

    // Wrap container is a power of two, so bytes*(len+1) reduces to a shift.
    assign wrap_shift = {1'b0, size_reg} + {1'b0, wrap_log};
    assign wrap_bytes = ADDR_W'(1) << wrap_shift;
    assign wrap_lower = addr_reg & ~(wrap_bytes - ADDR_W'(1));
    assign wrap_next  = (aligned_incr == wrap_lower + wrap_bytes) ? wrap_lower : aligned_incr;

`ifdef BURST_4K_CHECK_EN
    logic        bound_err_reg, bound_err_next;
    logic [11:0] page_bytes;
    logic [31:0] span_end;

    assign page_bytes = 12'd1 << size_clamped;
    assign span_end   = {20'd0, bus.base_addr[11:0] & ~(page_bytes - 12'd1)}
                      + ((32'(bus.len) + 32'd1) << size_clamped);
`endif

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        beat_cnt_next = beat_cnt_reg;
        len_next      = len_reg;
        size_next     = size_reg;
        burst_next    = burst_reg;
        done_next     = 1'b0;
`ifdef BURST_4K_CHECK_EN
        bound_err_next = bound_err_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    state_next    = BURST;
                    addr_next     = bus.base_addr;
                    beat_cnt_next = '0;
                    len_next      = bus.len;
                    size_next     = size_clamped;
                    burst_next    = bus.burst;
`ifdef BURST_4K_CHECK_EN
                    bound_err_next = (bus.burst[0] == 1'b1) && (span_end > 32'd4096);
`endif
                end
            end
            BURST: begin
                if (bus.adv) begin
                    if (last) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + LEN_W'(1);
                        case (burst_reg)
                            2'b00:   addr_next = addr_reg;
                            2'b10:   addr_next = wrap_legal ? wrap_next : aligned_incr;
                            default: addr_next = aligned_incr;
                        endcase
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            beat_cnt_reg <= '0;
            len_reg      <= '0;
            size_reg     <= '0;
            burst_reg    <= '0;
            done_reg     <= 1'b0;
`ifdef BURST_4K_CHECK_EN
            bound_err_reg <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            beat_cnt_reg <= beat_cnt_next;
            len_reg      <= len_next;
            size_reg     <= size_next;
            burst_reg    <= burst_next;
            done_reg     <= done_next;
`ifdef BURST_4K_CHECK_EN
            bound_err_reg <= bound_err_next;
`endif
        end
    end

    assign bus.busy     = busy;
    assign bus.addr     = addr_reg;
    assign bus.beat_cnt = beat_cnt_reg;
    assign bus.last     = last;
    assign bus.done     = done_reg;
`ifdef BURST_4K_CHECK_EN
    assign bus.bound_err = bound_err_reg;
`endif
endmodule
